// File: rtl/enigma_chan_mux_pkg.sv
// enigma_chan_mux_pkg: shared definitions for the enigma character channel mux.
//   mode_e        : selection mode encoding (static select / round-robin)
//   ENIGMA_CHAR_W : default character width of the datapath buses
//   wrap_add      : modular index addition used by the round-robin scan
//   wrap_next     : modular increment used for the round-robin pointer
package enigma_chan_mux_pkg;

   typedef enum logic {
      MODE_STATIC = 1'b0,
      MODE_RR     = 1'b1
   } mode_e;

   localparam int ENIGMA_CHAR_W = 8;

   // (base + off) mod n, valid for base < n and off < n
   function automatic int wrap_add(input int base, input int off, input int n);
      int sum_v;
      sum_v = base + off;
      if (sum_v >= n) begin
         sum_v = sum_v - n;
      end else begin
         sum_v = sum_v;
      end
      return sum_v;
   endfunction

   // (idx + 1) mod n, valid for idx < n
   function automatic int wrap_next(input int idx, input int n);
      int nxt_v;
      if (idx + 1 >= n) begin
         nxt_v = 0;
      end else begin
         nxt_v = idx + 1;
      end
      return nxt_v;
   endfunction

endpackage

// File: rtl/enigma_rr_arbiter.sv
// enigma_rr_arbiter: combinational round-robin arbiter.
// Scans req starting at rr_ptr, wrapping modulo N_CH, and grants the first
// requesting channel when enable is high.
//   req       in  N_CH  per-channel request
//   rr_ptr    in  CH_W  highest-priority channel for this decision
//   enable    in  1     grant permitted this cycle
//   grant     out N_CH  one-hot grant (all zero when nothing granted)
//   grant_idx out CH_W  encoded index of the granted channel
//   grant_any out 1     a grant was issued
module enigma_rr_arbiter
   import enigma_chan_mux_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int CH_W = 2
) (
   input  logic [N_CH-1:0] req,
   input  logic [CH_W-1:0] rr_ptr,
   input  logic            enable,
   output logic [N_CH-1:0] grant,
   output logic [CH_W-1:0] grant_idx,
   output logic            grant_any
);

   // Priority scan from rr_ptr; the first hit wins and masks later hits.
   always_comb begin
      int idx_v;
      grant     = {N_CH{1'b0}};
      grant_idx = {CH_W{1'b0}};
      grant_any = 1'b0;
      idx_v     = 0;
      for (int k = 0; k < N_CH; k++) begin
         idx_v = wrap_add(int'(rr_ptr), k, N_CH);
         if (enable && !grant_any && req[idx_v]) begin
            grant[idx_v] = 1'b1;
            grant_idx    = CH_W'(idx_v);
            grant_any    = 1'b1;
         end else begin
            grant_any = grant_any;
         end
      end
   end

endmodule

// File: rtl/enigma_chan_mux.sv
// enigma_chan_mux: N-channel registered selector for (valid + character)
// buses feeding the rotor pipeline. Static select or round-robin mode,
// valid/ready per channel, one output register stage tagged with the
// source channel index.
//   clk       in  1            rising-edge clock
//   rst_n     in  1            synchronous active-low reset
//   mode      in  1            0 = static select via sel, 1 = round-robin
//   sel       in  CH_W         static-mode channel select
//   in_valid  in  N_CH         per-channel valid
//   in_data   in  N_CH*DATA_W  flattened data, channel i at [i*DATA_W +: DATA_W]
//   in_ready  out N_CH         per-channel accept, one-hot or zero
//   out_valid out 1            output register holds a character
//   out_data  out DATA_W       registered character
//   out_ch    out CH_W         source channel of out_data
//   out_ready in  1            downstream accept
module enigma_chan_mux
   import enigma_chan_mux_pkg::*;
#(
   parameter int N_CH   = 4,
   parameter int CH_W   = 2,
   parameter int DATA_W = ENIGMA_CHAR_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     mode,
   input  logic [CH_W-1:0]          sel,
   input  logic [N_CH-1:0]          in_valid,
   input  logic [N_CH*DATA_W-1:0]   in_data,
   output logic [N_CH-1:0]          in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [CH_W-1:0]          out_ch,
   input  logic                     out_ready
);

   logic                load_en_s;
   logic                rr_en_s;
   logic [N_CH-1:0]     rr_oh_s;
   logic [CH_W-1:0]     rr_idx_s;
   logic                rr_any_s;
   logic [CH_W-1:0]     rr_next_s;
   logic [N_CH-1:0]     st_oh_s;
   logic [CH_W-1:0]     st_idx_s;
   logic                st_any_s;
   logic [N_CH-1:0]     gnt_oh_s;
   logic [CH_W-1:0]     gnt_idx_s;
   logic                gnt_any_s;
   logic [DATA_W-1:0]   gnt_data_s;

   logic                out_valid_r;
   logic [DATA_W-1:0]   out_data_r;
   logic [CH_W-1:0]     out_ch_r;
   logic [CH_W-1:0]     rr_ptr_r;

   // The register can take a new character when empty or being drained now;
   // this is the only path from out_ready to in_ready.
   assign load_en_s = !out_valid_r || out_ready;

   // Reset is folded into every grant enable so in_ready is low during reset.
   assign rr_en_s = rst_n && (mode == MODE_RR) && load_en_s;

   enigma_rr_arbiter #(
      .N_CH (N_CH),
      .CH_W (CH_W)
   ) u_rr_arb (
      .req       (in_valid),
      .rr_ptr    (rr_ptr_r),
      .enable    (rr_en_s),
      .grant     (rr_oh_s),
      .grant_idx (rr_idx_s),
      .grant_any (rr_any_s)
   );

   // Static-mode grant; matching sel against each legal index means an
   // out-of-range sel simply never matches.
   always_comb begin
      st_oh_s  = {N_CH{1'b0}};
      st_idx_s = {CH_W{1'b0}};
      st_any_s = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (rst_n && (mode == MODE_STATIC) && load_en_s &&
             (sel == CH_W'(i)) && in_valid[i]) begin
            st_oh_s[i] = 1'b1;
            st_idx_s   = CH_W'(i);
            st_any_s   = 1'b1;
         end else begin
            st_any_s = st_any_s;
         end
      end
   end

   // Pick the grant of the active mode.
   always_comb begin
      if (mode == MODE_RR) begin
         gnt_oh_s  = rr_oh_s;
         gnt_idx_s = rr_idx_s;
         gnt_any_s = rr_any_s;
      end else begin
         gnt_oh_s  = st_oh_s;
         gnt_idx_s = st_idx_s;
         gnt_any_s = st_any_s;
      end
   end

   // One-hot data select of the granted channel.
   always_comb begin
      gnt_data_s = {DATA_W{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
         if (gnt_oh_s[i]) begin
            gnt_data_s = in_data[i*DATA_W +: DATA_W];
         end else begin
            gnt_data_s = gnt_data_s;
         end
      end
   end

   // Round-robin pointer moves just past the channel that won.
   assign rr_next_s = CH_W'(wrap_next(int'(rr_idx_s), N_CH));

   assign in_ready = gnt_oh_s;

   // Output register and round-robin pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_data_r  <= {DATA_W{1'b0}};
         out_ch_r    <= {CH_W{1'b0}};
         rr_ptr_r    <= {CH_W{1'b0}};
      end else begin
         if (gnt_any_s) begin
            // Load wins over drain: back-to-back characters with no bubble.
            out_valid_r <= 1'b1;
            out_data_r  <= gnt_data_s;
            out_ch_r    <= gnt_idx_s;
         end else if (out_ready) begin
            // Drained with nothing new; data and channel keep their values.
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
         if (rr_any_s) begin
            rr_ptr_r <= rr_next_s;
         end else begin
            rr_ptr_r <= rr_ptr_r;
         end
      end
   end

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_enigma_chan_mux.sv
// tb_enigma_chan_mux: self-checking bench for enigma_chan_mux (N_CH=4, DATA_W=8).
// A cycle model predicts each grant; granted characters are pushed to a
// scoreboard queue and popped when the output register shows them.
module tb_enigma_chan_mux;

   localparam int N_CH   = 4;
   localparam int CH_W   = 2;
   localparam int DATA_W = 8;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   mode;
   logic [CH_W-1:0]        sel;
   logic [N_CH-1:0]        in_valid;
   logic [N_CH*DATA_W-1:0] in_data;
   logic [N_CH-1:0]        in_ready;
   logic                   out_valid;
   logic [DATA_W-1:0]      out_data;
   logic [CH_W-1:0]        out_ch;
   logic                   out_ready;

   // model state
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic [CH_W-1:0]   m_ch;
   logic [CH_W-1:0]   m_ptr;
   logic [N_CH-1:0]   exp_oh;
   logic [CH_W-1:0]   exp_idx;
   logic              exp_any;

   logic [CH_W+DATA_W-1:0] sb[$];
   logic [CH_W+DATA_W-1:0] item;
   logic [N_CH-1:0]        exp_rdy;

   int n_checks = 0;
   int n_fail   = 0;

   enigma_chan_mux #(
      .N_CH   (N_CH),
      .CH_W   (CH_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic set_data(input int ch, input logic [DATA_W-1:0] v);
      in_data[ch*DATA_W +: DATA_W] = v;
   endtask

   task automatic rand_data();
      for (int i = 0; i < N_CH; i++) begin
         set_data(i, 8'($urandom_range(0, 255)));
      end
   endtask

   // expected grant for the current inputs and model state
   task automatic predict();
      exp_oh  = 4'b0000;
      exp_idx = 2'd0;
      exp_any = 1'b0;
      if (rst_n === 1'b1 && (!m_valid || out_ready)) begin
         if (mode == 1'b0) begin
            if (in_valid[sel]) begin
               exp_any = 1'b1;
               exp_idx = sel;
            end
         end else begin
            for (int k = 0; k < N_CH; k++) begin
               int c;
               c = (int'(m_ptr) + k) % N_CH;
               if (!exp_any && in_valid[c]) begin
                  exp_any = 1'b1;
                  exp_idx = 2'(c);
               end
            end
         end
         if (exp_any) exp_oh[exp_idx] = 1'b1;
      end
   endtask

   // advance model and scoreboard across one rising edge
   task automatic clk_step();
      predict();
      if (rst_n !== 1'b1) begin
         m_valid = 1'b0;
         m_data  = 8'h00;
         m_ch    = 2'd0;
         m_ptr   = 2'd0;
      end else if (exp_any) begin
         sb.push_back({exp_idx, in_data[exp_idx*DATA_W +: DATA_W]});
         m_valid = 1'b1;
         m_data  = in_data[exp_idx*DATA_W +: DATA_W];
         m_ch    = exp_idx;
         if (mode) m_ptr = 2'(int'(exp_idx) + 1);
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mode = 1'b1; sel = 2'd0; out_ready = 1'b1; in_valid = 4'b1111;
      set_data(0, 8'h41); set_data(1, 8'h42); set_data(2, 8'h43); set_data(3, 8'h44);
      m_valid = 1'b0; m_data = 8'h00; m_ch = 2'd0; m_ptr = 2'd0;
      repeat (2) begin
         #1;
         n_checks++;
         if (in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 0000", in_ready);
         end
         clk_step();
      end
      n_checks++;
      if ({out_valid, out_data, out_ch} !== {1'b0, 8'h00, 2'd0}) begin
         n_fail++; $display("FAIL reset_out: got v=%b d=%h ch=%0d expected v=0 d=00 ch=0", out_valid, out_data, out_ch);
      end
      n_checks++;
      if (dut.rr_ptr_r !== 2'd0) begin
         n_fail++; $display("FAIL reset_ptr: got %0d expected 0", dut.rr_ptr_r);
      end
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 4'b0001) begin
         n_fail++; $display("FAIL reset_first_grant: got %b expected 0001", in_ready);
      end
      clk_step();
      n_checks++;
      if (sb.size() == 0) begin
         n_fail++; $display("FAIL reset_sb: got empty scoreboard expected entry");
      end else begin
         item = sb.pop_front();
         if ({out_valid, out_ch, out_data} !== {1'b1, item}) begin
            n_fail++; $display("FAIL reset_first_out: got v=%b ch=%0d d=%h expected ch=%0d d=%h", out_valid, out_ch, out_data, item[9:8], item[7:0]);
         end
      end
   endtask

   task automatic test_static();
      mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
      repeat (3) begin
         #1;
         n_checks++;
         if (in_ready !== 4'b0100) begin
            n_fail++; $display("FAIL static_ready: got %b expected 0100", in_ready);
         end
         clk_step();
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++; $display("FAIL static_sb: got empty scoreboard expected entry");
         end else begin
            item = sb.pop_front();
            if ({out_valid, out_ch, out_data} !== {1'b1, item} || out_data !== 8'h43) begin
               n_fail++; $display("FAIL static_out: got v=%b ch=%0d d=%h expected v=1 ch=2 d=43", out_valid, out_ch, out_data);
            end
         end
      end
      sel = 2'd3; in_valid = 4'b0111;
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) begin
         n_fail++; $display("FAIL static_sel3_ready: got %b expected 0000", in_ready);
      end
      clk_step();
      n_checks++;
      if ({out_valid, out_ch, out_data} !== {1'b0, 2'd2, 8'h43}) begin
         n_fail++; $display("FAIL static_drain: got v=%b ch=%0d d=%h expected v=0 ch=2 d=43", out_valid, out_ch, out_data);
      end
      n_checks++;
      if (dut.rr_ptr_r !== m_ptr) begin
         n_fail++; $display("FAIL static_ptr_hold: got %0d expected %0d", dut.rr_ptr_r, m_ptr);
      end
   endtask

   task automatic test_rr_fair();
      mode = 1'b1; in_valid = 4'b1000; set_data(3, 8'h33);
      #1;
      n_checks++;
      if (in_ready !== 4'b1000) begin
         n_fail++; $display("FAIL rr_prime_ready: got %b expected 1000", in_ready);
      end
      clk_step();
      item = sb.pop_front();
      n_checks++;
      if (dut.rr_ptr_r !== 2'd0 || {out_ch, out_data} !== item) begin
         n_fail++; $display("FAIL rr_wrap_ptr: got ptr=%0d ch=%0d expected ptr=0 ch=3", dut.rr_ptr_r, out_ch);
      end
      in_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         rand_data();
         exp_rdy = 4'b0001 << (k % 4);
         #1;
         n_checks++;
         if (in_ready !== exp_rdy) begin
            n_fail++; $display("FAIL rr_fair_ready[%0d]: got %b expected %b", k, in_ready, exp_rdy);
         end
         clk_step();
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++; $display("FAIL rr_fair_sb[%0d]: got empty scoreboard expected entry", k);
         end else begin
            item = sb.pop_front();
            if ({out_valid, out_ch, out_data} !== {1'b1, item} || out_ch !== 2'(k % 4)) begin
               n_fail++; $display("FAIL rr_fair_out[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h", k, out_valid, out_ch, out_data, k % 4, item[7:0]);
            end
         end
      end
   endtask

   task automatic test_rr_skip();
      in_valid = 4'b1001;
      for (int k = 0; k < 4; k++) begin
         rand_data();
         exp_rdy = (k % 2 == 1) ? 4'b1000 : 4'b0001;
         #1;
         n_checks++;
         if (in_ready !== exp_rdy) begin
            n_fail++; $display("FAIL rr_skip_ready[%0d]: got %b expected %b", k, in_ready, exp_rdy);
         end
         clk_step();
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++; $display("FAIL rr_skip_sb[%0d]: got empty scoreboard expected entry", k);
         end else begin
            item = sb.pop_front();
            if ({out_valid, out_ch, out_data} !== {1'b1, item}) begin
               n_fail++; $display("FAIL rr_skip_out[%0d]: got v=%b ch=%0d d=%h expected ch=%0d d=%h", k, out_valid, out_ch, out_data, item[9:8], item[7:0]);
            end
         end
         n_checks++;
         if (dut.rr_ptr_r !== ((k % 2 == 1) ? 2'd0 : 2'd1)) begin
            n_fail++; $display("FAIL rr_skip_ptr[%0d]: got %0d expected %0d", k, dut.rr_ptr_r, (k % 2 == 1) ? 0 : 1);
         end
      end
   endtask

   task automatic test_backpressure();
      in_valid = 4'b1111; out_ready = 1'b1; set_data(0, 8'h5A);
      #1;
      n_checks++;
      if (in_ready !== 4'b0001) begin
         n_fail++; $display("FAIL bp_load_ready: got %b expected 0001", in_ready);
      end
      clk_step();
      item = sb.pop_front();
      n_checks++;
      if ({out_valid, out_ch, out_data} !== {1'b1, item} || out_data !== 8'h5A) begin
         n_fail++; $display("FAIL bp_load_out: got v=%b d=%h expected v=1 d=5a", out_valid, out_data);
      end
      out_ready = 1'b0;
      repeat (5) begin
         rand_data();
         #1;
         n_checks++;
         if (in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL bp_ready: got %b expected 0000", in_ready);
         end
         clk_step();
         n_checks++;
         if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 8'h5A} || dut.rr_ptr_r !== 2'd1) begin
            n_fail++; $display("FAIL bp_hold: got v=%b ch=%0d d=%h ptr=%0d expected v=1 ch=0 d=5a ptr=1", out_valid, out_ch, out_data, dut.rr_ptr_r);
         end
      end
      out_ready = 1'b1; set_data(1, 8'h77);
      #1;
      n_checks++;
      if (in_ready !== 4'b0010) begin
         n_fail++; $display("FAIL bp_release_ready: got %b expected 0010", in_ready);
      end
      clk_step();
      n_checks++;
      if (sb.size() == 0) begin
         n_fail++; $display("FAIL bp_sb: got empty scoreboard expected entry");
      end else begin
         item = sb.pop_front();
         if ({out_valid, out_ch, out_data} !== {1'b1, item} || out_data !== 8'h77) begin
            n_fail++; $display("FAIL bp_release_out: got v=%b ch=%0d d=%h expected v=1 ch=1 d=77", out_valid, out_ch, out_data);
         end
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; in_valid = 4'b1111;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) begin
         n_fail++; $display("FAIL mid_reset_ready: got %b expected 0000", in_ready);
      end
      clk_step();
      n_checks++;
      if (out_valid !== 1'b0 || dut.rr_ptr_r !== 2'd0) begin
         n_fail++; $display("FAIL mid_reset_state: got v=%b ptr=%0d expected v=0 ptr=0", out_valid, dut.rr_ptr_r);
      end
      rst_n = 1'b1; in_valid = 4'b0000; out_ready = 1'b1;
      repeat (2) begin
         #1;
         clk_step();
         n_checks++;
         if (out_valid !== m_valid || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_no_replay: got v=%b expected v=0", out_valid);
         end
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++; $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
      end
   endtask

   initial begin
      in_data = '0;
      test_reset();
      test_static();
      test_rr_fair();
      test_rr_skip();
      test_backpressure();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
